// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the precise-exception controller.
// Holds the ExcCode values, the controller state encoding and the staged-slot record.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } ctrl_state_t;

    // One pipeline slot's view of the oldest exception seen so far for its instruction.
    typedef struct packed {
        logic       valid;
        logic [4:0] code;
        logic       bd;
    } exc_slot_t;

    localparam exc_slot_t SLOT_EMPTY = '0;

    // Restart address: a delay-slot instruction restarts at its branch.
    function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_stage.sv
// One staged exception slot: advances with the pipeline, holds on stall or
// takes a bubble, and keeps the first-detected exception of its instruction.
module exc_stage
    import exc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       hold,
    input  logic       bubble,
    input  exc_slot_t  prev,
    input  logic       exc_valid,
    input  logic [4:0] exc_code,
    input  logic       bd,
    output exc_slot_t  slot
);

    exc_slot_t next_slot;

    always_comb begin
        // NOTE: default every field first so no path leaves next_slot unassigned (no latch).
        next_slot    = prev;
        next_slot.bd = bd;
        if (!prev.valid && exc_valid) begin
            next_slot.valid = 1'b1;
            next_slot.code  = exc_code;
        end
    end

    // Flush beats hold: a stalled slot still empties when the pipeline is cleared.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state; reset is synchronous here.
        if (reset || flush || bubble) begin
            slot <= SLOT_EMPTY;
        end else if (!hold) begin
            slot <= next_slot;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Precise exception / interrupt / eret controller committing at the M stage.
// Tracks per-instruction exceptions through D/E/M and sequences the redirect.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] NOP_PC     = 32'h1823_1051
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        iExcValidF,
    input  logic [4:0]  iExcF,
    input  logic        iExcValidD,
    input  logic [4:0]  iExcD,
    input  logic        iExcValidE,
    input  logic [4:0]  iExcE,
    input  logic        iBDD,
    input  logic [31:0] iPCM,
    input  logic        iEretM,
    input  logic [5:0]  iHWInt,
    input  logic [5:0]  iIM,
    input  logic        iIE,
    input  logic        iEXL,
    input  logic [31:0] iEPC,
    output logic        oTake,
    output logic [4:0]  oExcCode,
    output logic        oBD,
    output logic [31:0] oEPC,
    output logic        oEXLclr,
    output logic        oFlush,
    output logic        oRedirect,
    output logic [31:0] oNPC
);

    ctrl_state_t state;
    logic        flush_q;
    logic        redirect_q;
    exc_slot_t   slot_d;
    exc_slot_t   slot_e;
    exc_slot_t   slot_m;
    logic        in_run;
    logic        pc_valid;
    logic        int_req;
    logic        take;
    logic        eret_commit;

    exc_stage u_stage_d (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_q),
        .hold      (stall),
        .bubble    (1'b0),
        .prev      (SLOT_EMPTY),
        .exc_valid (iExcValidF),
        .exc_code  (iExcF),
        .bd        (1'b0),
        .slot      (slot_d)
    );

    exc_stage u_stage_e (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_q),
        .hold      (stall),
        .bubble    (1'b0),
        .prev      (slot_d),
        .exc_valid (iExcValidD),
        .exc_code  (iExcD),
        .bd        (iBDD),
        .slot      (slot_e)
    );

    // E->M inserts a bubble on stall instead of holding.
    exc_stage u_stage_m (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_q),
        .hold      (1'b0),
        .bubble    (stall),
        .prev      (slot_e),
        .exc_valid (iExcValidE),
        .exc_code  (iExcE),
        .bd        (slot_e.bd),
        .slot      (slot_m)
    );

    assign in_run   = (state == ST_RUN);
    assign pc_valid = (iPCM != NOP_PC);
    assign int_req  = (|(iHWInt & iIM)) & iIE & ~iEXL;

    // A pending interrupt waits for a real instruction in M so EPC is meaningful.
    assign take        = ~reset & in_run & pc_valid & (int_req | slot_m.valid);
    assign eret_commit = ~reset & in_run & pc_valid & iEretM & ~int_req & ~slot_m.valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (take) begin
                        state      <= ST_TRAP;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                    end else if (eret_commit) begin
                        state      <= ST_RET;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    flush_q    <= 1'b0;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        oTake    = take;
        oEXLclr  = eret_commit;
        oExcCode = '0;
        oBD      = 1'b0;
        oEPC     = '0;
        if (take) begin
            oExcCode = int_req ? EXC_INT : slot_m.code;
            oBD      = slot_m.bd;
            oEPC     = restart_pc(iPCM, slot_m.bd);
        end
        unique case (state)
            ST_TRAP: oNPC = HANDLER_PC;
            ST_RET:  oNPC = iEPC;
            default: oNPC = '0;
        endcase
    end

    assign oFlush    = flush_q;
    assign oRedirect = redirect_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: an instruction-level pipeline model predicts
// each commit event; a negedge monitor compares whatever the DUT presents.
module tb_exc_ctrl;

    localparam logic [31:0] HANDLER = 32'h0000_4180;
    localparam logic [31:0] NOP     = 32'h1823_1051;
    localparam logic [4:0]  C_INT = 5'd0,  C_ADEL = 5'd4, C_ADES = 5'd5;
    localparam logic [4:0]  C_SYS = 5'd8,  C_RI   = 5'd10, C_OV  = 5'd12;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        iExcValidF, iExcValidD, iExcValidE, iBDD, iEretM, iIE, iEXL;
    logic [4:0]  iExcF, iExcD, iExcE;
    logic [31:0] iPCM, iEPC;
    logic [5:0]  iHWInt, iIM;
    logic        oTake, oBD, oEXLclr, oFlush, oRedirect;
    logic [4:0]  oExcCode;
    logic [31:0] oEPC, oNPC;

    always #5 clk = ~clk;

    exc_ctrl #(.HANDLER_PC(HANDLER), .NOP_PC(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .iExcValidF(iExcValidF), .iExcF(iExcF),
        .iExcValidD(iExcValidD), .iExcD(iExcD),
        .iExcValidE(iExcValidE), .iExcE(iExcE),
        .iBDD(iBDD), .iPCM(iPCM), .iEretM(iEretM),
        .iHWInt(iHWInt), .iIM(iIM), .iIE(iIE), .iEXL(iEXL), .iEPC(iEPC),
        .oTake(oTake), .oExcCode(oExcCode), .oBD(oBD), .oEPC(oEPC),
        .oEXLclr(oEXLclr), .oFlush(oFlush), .oRedirect(oRedirect), .oNPC(oNPC)
    );

    // An instruction carries every exception any stage will report for it.
    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic [4:0]  fc;
        logic        dv;
        logic [4:0]  dc;
        logic        ev;
        logic [4:0]  ec;
        logic        bd;
        logic        eret;
    } instr_t;

    typedef struct packed {
        logic        take;
        logic        exlclr;
        logic        flush;
        logic        redirect;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        logic [31:0] npc;
    } resp_t;

    typedef struct {
        int    cyc;
        resp_t r;
    } exp_t;

    typedef enum {REC_NONE, REC_TRAP, REC_RET} rec_t;

    exp_t   sb[$];
    instr_t fetch_q[$];
    instr_t pf, pd, pe, pm, t;
    rec_t   rec;
    int     cyc, n_tests, n_fail;
    bit     mon_en, rand_mode;
    logic        k_stall, k_ie, k_exl;
    logic [5:0]  k_hw, k_im;
    logic [31:0] k_epc;
    resp_t  mon_act;
    exp_t   mon_e;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic instr_t bubble_i();
        instr_t b;
        b    = '0;
        b.pc = NOP;
        return b;
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input logic bd);
        instr_t i;
        i    = '0;
        i.pc = pc;
        i.bd = bd;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        if ($urandom_range(3) == 0) return bubble_i();
        i    = '0;
        i.pc = $urandom();
        if (i.pc == NOP) i.pc = 32'h0000_3000;
        i.bd = ($urandom_range(3) == 0);
        if ($urandom_range(9) == 0) begin i.fv = 1'b1; i.fc = C_ADEL; end
        if ($urandom_range(9) == 0) begin i.dv = 1'b1; i.dc = ($urandom_range(1) == 0) ? C_RI : C_SYS; end
        if ($urandom_range(9) == 0) begin
            i.ev = 1'b1;
            case ($urandom_range(2))
                0:       i.ec = C_OV;
                1:       i.ec = C_ADEL;
                default: i.ec = C_ADES;
            endcase
        end
        i.eret = ($urandom_range(11) == 0);
        return i;
    endfunction

    // Oldest stage wins: {valid, code}.
    function automatic logic [5:0] first_exc(input instr_t i);
        if (i.fv) return {1'b1, i.fc};
        if (i.dv) return {1'b1, i.dc};
        if (i.ev) return {1'b1, i.ec};
        return 6'd0;
    endfunction

    function automatic instr_t next_fetch();
        if (fetch_q.size() > 0) return fetch_q.pop_front();
        if (rand_mode) return rand_instr();
        return bubble_i();
    endfunction

    task automatic quiet();
        k_stall = 1'b0; k_hw = '0; k_im = '0; k_ie = 1'b0; k_exl = 1'b0; k_epc = '0;
    endtask

    task automatic run_cycle(input bit rst);
        exp_t       e;
        rec_t       nrec;
        logic       irq;
        logic [5:0] fx;
        if (rand_mode) begin
            k_stall = ($urandom_range(4) == 0);
            k_hw    = 6'($urandom());
            k_im    = 6'($urandom());
            k_ie    = ($urandom_range(9) == 0);
            k_exl   = ($urandom_range(3) == 0);
            k_epc   = $urandom();
        end
        reset = rst; stall = k_stall;
        iHWInt = k_hw; iIM = k_im; iIE = k_ie; iEXL = k_exl; iEPC = k_epc;
        iExcValidF = pf.fv; iExcF = pf.fc;
        iExcValidD = pd.dv; iExcD = pd.dc; iBDD = pd.bd;
        iExcValidE = pe.ev; iExcE = pe.ec;
        iPCM = pm.pc; iEretM = pm.eret;

        e.cyc = cyc;
        e.r   = '0;
        nrec  = REC_NONE;
        irq   = (|(k_hw & k_im)) && k_ie && !k_exl;
        if (rec != REC_NONE) begin
            e.r.flush    = 1'b1;
            e.r.redirect = 1'b1;
            e.r.npc      = (rec == REC_TRAP) ? HANDLER : k_epc;
            sb.push_back(e);
        end else if (!rst && pm.pc != NOP) begin
            fx = first_exc(pm);
            if (irq || fx[5]) begin
                e.r.take = 1'b1;
                e.r.code = irq ? C_INT : fx[4:0];
                e.r.bd   = pm.bd;
                e.r.epc  = pm.bd ? pm.pc - 32'd4 : pm.pc;
                sb.push_back(e);
                nrec = REC_TRAP;
            end else if (pm.eret) begin
                e.r.exlclr = 1'b1;
                sb.push_back(e);
                nrec = REC_RET;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rst || rec != REC_NONE) begin
            pd = bubble_i(); pe = bubble_i(); pm = bubble_i();
            pf = next_fetch();
            rec = REC_NONE;
        end else begin
            rec = nrec;
            if (k_stall) begin
                pm = bubble_i();
            end else begin
                pm = pe; pe = pd; pd = pf;
                pf = next_fetch();
            end
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = {oTake, oEXLclr, oFlush, oRedirect, oExcCode, oBD, oEPC, oNPC};
            if (oTake || oEXLclr || oFlush || oRedirect) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 96'(mon_act), 96'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("event_cycle", 96'(cyc), 96'(mon_e.cyc));
                    check("event_resp", 96'(mon_act), 96'(mon_e.r));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                check("missed_event", 96'(mon_act), 96'(mon_e.r));
            end else begin
                check("idle_outputs", 96'(mon_act), 96'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; mon_en = 0; rand_mode = 0;
        rec = REC_NONE;
        pf = bubble_i(); pd = bubble_i(); pe = bubble_i(); pm = bubble_i();
        quiet();

        run_cycle(1'b1);
        mon_en = 1;
        run_cycle(1'b1);
        check("reset_state", 96'({oFlush, oRedirect, oNPC}), 96'(0));
        run_n(4);

        // RI detected in D at 0x3008
        t = mk(32'h0000_3008, 1'b0); t.dv = 1'b1; t.dc = C_RI; fetch_q.push_back(t);
        run_n(8);

        // Ov in E on a delay-slot instruction
        t = mk(32'h0000_3010, 1'b1); t.ev = 1'b1; t.ec = C_OV; fetch_q.push_back(t);
        run_n(8);

        // Fetch AdEL and decode RI on the same instruction
        t = mk(32'h0000_3030, 1'b0); t.fv = 1'b1; t.fc = C_ADEL; t.dv = 1'b1; t.dc = C_RI;
        fetch_q.push_back(t);
        run_n(8);

        // eret returning to 0x3040
        k_epc = 32'h0000_3040;
        t = mk(32'h0000_3038, 1'b0); t.eret = 1'b1; fetch_q.push_back(t);
        run_n(8);
        quiet();

        // Interrupt pending across bubbles, taken at 0x3020
        k_hw = 6'b000100; k_im = 6'b000100; k_ie = 1'b1; k_exl = 1'b0;
        fetch_q.push_back(bubble_i());
        fetch_q.push_back(bubble_i());
        fetch_q.push_back(mk(32'h0000_3020, 1'b0));
        run_n(10);
        quiet();

        // Masked interrupts: IM clear, then EXL set
        k_hw = 6'h3F; k_ie = 1'b1;
        fetch_q.push_back(mk(32'h0000_3050, 1'b0));
        run_n(6);
        k_im = 6'h3F; k_exl = 1'b1;
        fetch_q.push_back(mk(32'h0000_3054, 1'b0));
        run_n(6);
        quiet();

        // EPC wraps modulo 2^32 and keeps low bits
        t = mk(32'h0000_0002, 1'b1); t.dv = 1'b1; t.dc = C_SYS; fetch_q.push_back(t);
        run_n(8);

        // Ov held in E across a stall
        t = mk(32'h0000_3060, 1'b0); t.ev = 1'b1; t.ec = C_OV; fetch_q.push_back(t);
        run_n(3);
        k_stall = 1'b1;
        run_n(3);
        k_stall = 1'b0;
        run_n(8);

        // Reset asserted during TRAP
        t = mk(32'h0000_3070, 1'b0); t.dv = 1'b1; t.dc = C_RI; fetch_q.push_back(t);
        t = mk(32'h0000_3074, 1'b0); t.dv = 1'b1; t.dc = C_RI; fetch_q.push_back(t);
        for (int i = 0; i < 20 && rec != REC_TRAP; i++) run_cycle(1'b0);
        check("trap_reached", 96'(rec == REC_TRAP), 96'(1));
        run_cycle(1'b1);
        check("reset_in_trap", 96'({oFlush, oRedirect, oNPC}), 96'(0));
        run_n(8);

        rand_mode = 1;
        for (int i = 0; i < 3000; i++) run_cycle($urandom_range(299) == 0);
        rand_mode = 0;
        quiet();
        run_n(8);

        check("scoreboard_empty", 96'(sb.size()), 96'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
